// File: rtl/i2c_reg_sequencer.sv
// I2C register sequencer: turns one host register read/write into the master's
// start / byte-write / byte-read / stop primitives and returns a single response.
module i2c_reg_sequencer #(
  parameter int unsigned ADDRESS_BITS   = 7,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic                    reqRead,
  input  logic [ADDRESS_BITS-1:0] reqDevAddr,
  input  logic [7:0]              reqRegAddr,
  input  logic [7:0]              reqWrData,
  output logic                    rspValid,
  input  logic                    rspReady,
  output logic [7:0]              rspData,
  output logic                    rspNack,
  output logic                    rspTimeout,
  output logic [9:0]              mDIn,
  output logic                    mReadNWrite,
  output logic                    mStart,
  output logic                    mStop,
  output logic                    mSendAck,
  input  logic [7:0]              mDOut,
  input  logic                    mDOutStrobe,
  input  logic                    mRecvAck,
  input  logic                    mBusy
);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitHi, StWaitLo, StToStop, StResp} state_e;
  typedef enum logic [2:0] {
    StepStartW, StepWrReg, StepWrData, StepStartR, StepRead, StepStop
  } step_e;

  localparam logic [19:0] TimerLast = 20'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  step_e                   step_q, step_d;
  logic                    read_q, read_d;
  logic [ADDRESS_BITS-1:0] dev_q, dev_d;
  logic [7:0]              reg_q, reg_d;
  logic [7:0]              wdata_q, wdata_d;
  logic [19:0]             timer_q, timer_d;
  logic [7:0]              rd_byte_q, rd_byte_d;
  logic                    rd_seen_q, rd_seen_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [7:0]              rsp_data_q, rsp_data_d;
  logic                    rsp_nack_q, rsp_nack_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [9:0]              m_din_q, m_din_d;
  logic                    m_rnw_q, m_rnw_d;
  logic                    m_start_q, m_start_d;
  logic                    m_stop_q, m_stop_d;
  logic                    timeout;

  // Next-state: step sequencing, timer, NACK/timeout handling, registered command lines.
  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    read_d        = read_q;
    dev_d         = dev_q;
    reg_d         = reg_q;
    wdata_d       = wdata_q;
    timer_d       = timer_q;
    rd_byte_d     = rd_byte_q;
    rd_seen_d     = rd_seen_q;
    rsp_data_d    = rsp_data_q;
    rsp_nack_d    = rsp_nack_q;
    rsp_timeout_d = rsp_timeout_q;
    m_din_d       = m_din_q;
    m_rnw_d       = m_rnw_q;
    m_start_d     = m_start_q;
    m_stop_d      = m_stop_q;
    timeout       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (reqValid && req_ready_q) begin
          read_d        = reqRead;
          dev_d         = reqDevAddr;
          reg_d         = reqRegAddr;
          wdata_d       = reqWrData;
          step_d        = StepStartW;
          rd_seen_d     = 1'b0;
          rsp_data_d    = 8'h00;
          rsp_nack_d    = 1'b0;
          rsp_timeout_d = 1'b0;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        timer_d   = '0;
        m_start_d = 1'b0;
        m_stop_d  = 1'b0;
        m_rnw_d   = 1'b0;
        m_din_d   = '0;
        case (step_q)
          StepStartW: begin m_start_d = 1'b1; m_din_d = 10'(dev_q); end
          StepStartR: begin m_start_d = 1'b1; m_rnw_d = 1'b1; m_din_d = 10'(dev_q); end
          StepWrReg:  m_din_d = {2'b00, reg_q};
          StepWrData: m_din_d = {2'b00, wdata_q};
          StepRead:   m_rnw_d = 1'b1;
          default:    m_stop_d = 1'b1;
        endcase
        state_d = StWaitHi;
      end
      StWaitHi: begin
        if (timer_q == TimerLast) begin
          timeout = 1'b1;
        end else begin
          timer_d = timer_q + 20'd1;
          if (mBusy) begin
            m_start_d = 1'b0;
            m_stop_d  = 1'b0;
            state_d   = StWaitLo;
          end
        end
      end
      StWaitLo: begin
        if (timer_q == TimerLast) begin
          timeout = 1'b1;
        end else begin
          timer_d = timer_q + 20'd1;
          if (mDOutStrobe && step_q == StepRead) begin
            rd_byte_d = mDOut;
            rd_seen_d = 1'b1;
          end
          if (!mBusy) begin
            state_d = StIssue;
            // A NACK on any address/write slot skips straight to STOP.
            case (step_q)
              StepStartW: step_d = mRecvAck ? StepWrReg : StepStop;
              StepWrReg:  step_d = !mRecvAck ? StepStop : (read_q ? StepStartR : StepWrData);
              StepWrData: step_d = StepStop;
              StepStartR: step_d = mRecvAck ? StepRead : StepStop;
              StepRead: begin
                rsp_data_d = (mDOutStrobe || !rd_seen_q) ? mDOut : rd_byte_q;
                step_d     = StepStop;
              end
              default: state_d = StResp;
            endcase
            if (!mRecvAck && step_q != StepRead && step_q != StepStop) begin
              rsp_nack_d = 1'b1;
            end
          end
        end
      end
      StToStop: begin
        state_d = StResp;
      end
      StResp: begin
        if (rspReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort: one stop pulse unless the stop itself hung, then report.
    if (timeout) begin
      rsp_timeout_d = 1'b1;
      m_start_d     = 1'b0;
      if (step_q == StepStop) begin
        state_d = StResp;
      end else begin
        m_stop_d = 1'b1;
        state_d  = StToStop;
      end
    end

    if (state_d == StResp) begin
      m_start_d = 1'b0;
      m_stop_d  = 1'b0;
      m_rnw_d   = 1'b0;
      m_din_d   = '0;
    end
    req_ready_d = (state_d == StIdle);
    rsp_valid_d = (state_d == StResp);
  end

  // State and registered outputs; async reset drops any transaction in flight.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= StIdle;
      step_q        <= StepStartW;
      read_q        <= 1'b0;
      dev_q         <= '0;
      reg_q         <= 8'h00;
      wdata_q       <= 8'h00;
      timer_q       <= '0;
      rd_byte_q     <= 8'h00;
      rd_seen_q     <= 1'b0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 8'h00;
      rsp_nack_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
      m_din_q       <= '0;
      m_rnw_q       <= 1'b0;
      m_start_q     <= 1'b0;
      m_stop_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      read_q        <= read_d;
      dev_q         <= dev_d;
      reg_q         <= reg_d;
      wdata_q       <= wdata_d;
      timer_q       <= timer_d;
      rd_byte_q     <= rd_byte_d;
      rd_seen_q     <= rd_seen_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_nack_q    <= rsp_nack_d;
      rsp_timeout_q <= rsp_timeout_d;
      m_din_q       <= m_din_d;
      m_rnw_q       <= m_rnw_d;
      m_start_q     <= m_start_d;
      m_stop_q      <= m_stop_d;
    end
  end

  assign reqReady    = req_ready_q;
  assign rspValid    = rsp_valid_q;
  assign rspData     = rsp_data_q;
  assign rspNack     = rsp_nack_q;
  assign rspTimeout  = rsp_timeout_q;
  assign mDIn        = m_din_q;
  assign mReadNWrite = m_rnw_q;
  assign mStart      = m_start_q;
  assign mStop       = m_stop_q;
  // Single-byte reads always end with NACK from the master.
  assign mSendAck    = 1'b0;

endmodule
